// File: rtl/carfield_l2_port_sched.sv
// rtl/carfield_l2_port_sched.sv - shares two L2 ports among NumReq requesters with per-port round-robin
module carfield_l2_port_sched #(
    parameter int unsigned          NumReq    = 4,
    parameter int unsigned          AddrWidth = 48,
    parameter int unsigned          DataWidth = 64,
    parameter logic [AddrWidth-1:0] Port0Base = 'h7800_0000,
    parameter logic [AddrWidth-1:0] PortSize  = 'h0002_0000,
    localparam int unsigned         OffW      = $clog2(PortSize)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
    input  logic [NumReq-1:0]                   req_we_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
    output logic [NumReq-1:0]                   rsp_valid_o,
    output logic [NumReq-1:0]                   rsp_err_o,
    output logic [DataWidth-1:0]                rsp_rdata_o,
    output logic [1:0]                          port_req_o,
    input  logic [1:0]                          port_gnt_i,
    output logic [1:0][OffW-1:0]                port_addr_o,
    output logic [1:0]                          port_we_o,
    output logic [1:0][DataWidth-1:0]           port_wdata_o,
    input  logic [1:0]                          port_rvalid_i,
    input  logic [1:0][DataWidth-1:0]           port_rdata_i
);
    localparam int unsigned IdxW = $clog2(NumReq);
    localparam logic [AddrWidth-1:0] P1Base = Port0Base + PortSize;
    localparam logic [AddrWidth-1:0] P1End  = P1Base + PortSize;
    localparam logic [1:0][AddrWidth-1:0] Base = {P1Base, Port0Base};

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e [1:0]                state_q, state_d;
    logic [1:0][IdxW-1:0]        rr_ptr_q, idx_q, win_idx;
    logic [1:0]                  win_ok, accept, can_arb, deliver, pend_q;
    logic [1:0][OffW-1:0]        off_d;
    logic [1:0][DataWidth-1:0]   hold_q;
    logic [1:0][NumReq-1:0]      hit;
    logic [NumReq-1:0]           hit_err, busy_q;
    logic                        err_ok, err_pend_q;
    logic [IdxW-1:0]             err_idx, err_idx_q;
    logic [1:0]                  we_q;
    logic [1:0][OffW-1:0]        addr_q;
    logic [1:0][DataWidth-1:0]   wdata_q;

    // Address decode of every non-busy valid requester into port 0, port 1 or error
    always_comb begin
        hit     = '0;
        hit_err = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (req_valid_i[i] && !busy_q[i]) begin
                if (req_addr_i[i] >= Port0Base && req_addr_i[i] < P1Base)
                    hit[0][i] = 1'b1;
                else if (req_addr_i[i] >= P1Base && req_addr_i[i] < P1End)
                    hit[1][i] = 1'b1;
                else
                    hit_err[i] = 1'b1;
            end
        end
    end

    // Round-robin pick per port (descending scan so the first index at/after rr_ptr wins),
    // lowest-index pick for the error path, and the response/ready steering
    always_comb begin
        int j;
        win_ok      = '0;
        win_idx     = '0;
        off_d       = '0;
        err_ok      = 1'b0;
        err_idx     = '0;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_err_o   = '0;
        rsp_rdata_o = '0;
        // Port 0 always drains first; port 1 waits while port 0 holds a response
        deliver[0]  = pend_q[0];
        deliver[1]  = pend_q[1] && !pend_q[0];
        for (int p = 0; p < 2; p++) begin
            for (int i = int'(NumReq) - 1; i >= 0; i--) begin
                j = int'(rr_ptr_q[p]) + i;
                if (j >= int'(NumReq)) j = j - int'(NumReq);
                if (hit[p][IdxW'(j)]) begin
                    win_ok[p]  = 1'b1;
                    win_idx[p] = IdxW'(j);
                end
            end
            off_d[p]   = OffW'(req_addr_i[win_idx[p]] - Base[p]);
            // A port holding an undelivered response stays out of arbitration
            can_arb[p] = (state_q[p] == IDLE) && (!pend_q[p] || deliver[p]);
            accept[p]  = can_arb[p] && win_ok[p];
            if (accept[p]) req_ready_o[win_idx[p]] = 1'b1;
            if (deliver[p]) rsp_valid_o[idx_q[p]] = 1'b1;
        end
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            if (hit_err[i]) begin
                err_ok  = 1'b1;
                err_idx = IdxW'(i);
            end
        end
        if (err_ok) req_ready_o[err_idx] = 1'b1;
        if (err_pend_q) begin
            rsp_valid_o[err_idx_q] = 1'b1;
            rsp_err_o[err_idx_q]   = 1'b1;
        end
        if (deliver[0])      rsp_rdata_o = hold_q[0];
        else if (deliver[1]) rsp_rdata_o = hold_q[1];
    end

    // Per-port FSM next state and L2 request strobe
    always_comb begin
        state_d    = state_q;
        port_req_o = '0;
        for (int p = 0; p < 2; p++) begin
            case (state_q[p])
                IDLE: if (accept[p]) state_d[p] = REQ;
                REQ: begin
                    port_req_o[p] = 1'b1;
                    if (port_gnt_i[p]) state_d[p] = WAIT;
                end
                WAIT: if (port_rvalid_i[p]) state_d[p] = IDLE;
                default: state_d[p] = IDLE;
            endcase
        end
    end

    assign port_addr_o  = addr_q;
    assign port_we_o    = we_q;
    assign port_wdata_o = wdata_q;

    // State, captured transaction, response holding registers and busy bits
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= {IDLE, IDLE};
            rr_ptr_q   <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            we_q       <= '0;
            wdata_q    <= '0;
            pend_q     <= '0;
            hold_q     <= '0;
            busy_q     <= '0;
            err_pend_q <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            state_q <= state_d;
            for (int p = 0; p < 2; p++) begin
                if (accept[p]) begin
                    idx_q[p]    <= win_idx[p];
                    addr_q[p]   <= off_d[p];
                    we_q[p]     <= req_we_i[win_idx[p]];
                    wdata_q[p]  <= req_wdata_i[win_idx[p]];
                    rr_ptr_q[p] <= (win_idx[p] == IdxW'(NumReq - 1)) ? '0 : win_idx[p] + 1'b1;
                end
                if (state_q[p] == WAIT && port_rvalid_i[p]) begin
                    pend_q[p] <= 1'b1;
                    hold_q[p] <= port_rdata_i[p];
                end else if (deliver[p]) begin
                    pend_q[p] <= 1'b0;
                end
            end
            busy_q     <= (busy_q | req_ready_o) & ~rsp_valid_o;
            err_pend_q <= err_ok;
            if (err_ok) err_idx_q <= err_idx;
        end
    end
endmodule

// File: tb/tb_carfield_l2_port_sched.sv
// tb/tb_carfield_l2_port_sched.sv - vector-table and directed-sequence bench for carfield_l2_port_sched
module tb_carfield_l2_port_sched;
    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic [3:0]            req_valid, req_ready, req_we, rsp_valid, rsp_err;
    logic [3:0][47:0]      req_addr;
    logic [3:0][63:0]      req_wdata;
    logic [63:0]           rsp_rdata;
    logic [1:0]            port_req, port_gnt, port_we, port_rvalid;
    logic [1:0][16:0]      port_addr;
    logic [1:0][63:0]      port_wdata, port_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    carfield_l2_port_sched dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_we_i(req_we), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata),
        .port_req_o(port_req), .port_gnt_i(port_gnt), .port_addr_o(port_addr),
        .port_we_o(port_we), .port_wdata_o(port_wdata),
        .port_rvalid_i(port_rvalid), .port_rdata_i(port_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       valid;
        logic [3:0][47:0] addr;
        logic [1:0]       gnt, rv;
        logic [63:0]      rd0, rd1;
        logic [3:0]       e_ready, e_rsp, e_err;
        logic [63:0]      e_rdata;
        logic [1:0]       e_preq;
        logic [16:0]      e_pa0, e_pa1;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic [3:0] v, input logic [47:0] a0, a1, a2, a3,
                                input logic [1:0] g, r, input logic [63:0] d0, d1,
                                input logic [3:0] er, ev, ee, input logic [63:0] ed,
                                input logic [1:0] ep, input logic [16:0] e0, e1);
        vec_t x;
        x.valid = v; x.addr = {a3, a2, a1, a0}; x.gnt = g; x.rv = r; x.rd0 = d0; x.rd1 = d1;
        x.e_ready = er; x.e_rsp = ev; x.e_err = ee; x.e_rdata = ed; x.e_preq = ep;
        x.e_pa0 = e0; x.e_pa1 = e1;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_addr = '0; req_we = '0; req_wdata = '0;
        port_gnt = '0; port_rvalid = '0; port_rdata = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n_acc;
        int exp_rr;
        // cycle-by-cycle script: single read, parallel ports, decode errors, window boundaries
        tbl[0]  = mk(4'b0001, 48'h7800_0010, 0, 0, 0, 2'b00, 2'b00, 0, 0,  4'b0001, 4'b0000, 4'b0000, 0, 2'b00, 17'h0, 17'h0);
        tbl[1]  = mk(4'b0000, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0,               4'b0000, 4'b0000, 4'b0000, 0, 2'b01, 17'h10, 17'h0);
        tbl[2]  = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b01, 64'hABCD, 0,        4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 17'h10, 17'h0);
        tbl[3]  = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0,               4'b0000, 4'b0001, 4'b0000, 64'hABCD, 2'b00, 17'h10, 17'h0);
        tbl[4]  = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0,               4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 17'h10, 17'h0);
        tbl[5]  = mk(4'b0011, 48'h7800_0000, 48'h7802_0008, 0, 0, 2'b00, 2'b00, 0, 0, 4'b0011, 4'b0000, 4'b0000, 0, 2'b00, 17'h10, 17'h0);
        tbl[6]  = mk(4'b0000, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0,               4'b0000, 4'b0000, 4'b0000, 0, 2'b11, 17'h0, 17'h8);
        tbl[7]  = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b11, 64'h1111, 64'h2222, 4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 17'h0, 17'h8);
        tbl[8]  = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0,               4'b0000, 4'b0001, 4'b0000, 64'h1111, 2'b00, 17'h0, 17'h8);
        tbl[9]  = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0,               4'b0000, 4'b0010, 4'b0000, 64'h2222, 2'b00, 17'h0, 17'h8);
        tbl[10] = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0,               4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 17'h0, 17'h8);
        tbl[11] = mk(4'b1000, 0, 0, 0, 48'h7804_0000, 2'b00, 2'b00, 0, 0,   4'b1000, 4'b0000, 4'b0000, 0, 2'b00, 17'h0, 17'h8);
        tbl[12] = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0,               4'b0000, 4'b1000, 4'b1000, 0, 2'b00, 17'h0, 17'h8);
        tbl[13] = mk(4'b0011, 48'h7801_FFFF, 48'h77FF_FFFF, 0, 0, 2'b00, 2'b00, 0, 0, 4'b0011, 4'b0000, 4'b0000, 0, 2'b00, 17'h0, 17'h8);
        tbl[14] = mk(4'b0000, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0,               4'b0000, 4'b0010, 4'b0010, 0, 2'b01, 17'h1FFFF, 17'h8);
        tbl[15] = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b01, 64'h5, 0,           4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 17'h1FFFF, 17'h8);
        tbl[16] = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0,               4'b0000, 4'b0001, 4'b0000, 64'h5, 2'b00, 17'h1FFFF, 17'h8);
        tbl[17] = mk(4'b1100, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0,               4'b0100, 4'b0000, 4'b0000, 0, 2'b00, 17'h1FFFF, 17'h8);
        tbl[18] = mk(4'b1000, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0,               4'b1000, 4'b0100, 4'b0100, 0, 2'b00, 17'h1FFFF, 17'h8);
        tbl[19] = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0,               4'b0000, 4'b1000, 4'b1000, 0, 2'b00, 17'h1FFFF, 17'h8);

        idle_inputs();
        do_reset();
        #1;
        chk("reset_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_port_req", port_req, 0);
        chk("reset_port_addr", port_addr, 0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req_valid = tbl[i].valid; req_addr = tbl[i].addr;
            port_gnt = tbl[i].gnt; port_rvalid = tbl[i].rv;
            port_rdata[0] = tbl[i].rd0; port_rdata[1] = tbl[i].rd1;
            #1;
            chk($sformatf("v%0d_ready", i), req_ready, tbl[i].e_ready);
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, tbl[i].e_rsp);
            chk($sformatf("v%0d_rsp_err", i), rsp_err, tbl[i].e_err);
            chk($sformatf("v%0d_rdata", i), rsp_rdata, tbl[i].e_rdata);
            chk($sformatf("v%0d_port_req", i), port_req, tbl[i].e_preq);
            chk($sformatf("v%0d_port_addr0", i), port_addr[0], tbl[i].e_pa0);
            chk($sformatf("v%0d_port_addr1", i), port_addr[1], tbl[i].e_pa1);
        end

        // round-robin: three requesters hammer port 0 with a zero-wait L2
        @(negedge clk);
        idle_inputs();
        do_reset();
        req_valid = 4'b0111;
        req_addr[0] = 48'h7800_0000; req_addr[1] = 48'h7800_0008; req_addr[2] = 48'h7800_0010;
        port_gnt = 2'b01; port_rvalid = 2'b01;
        n_acc = 0; exp_rr = 0;
        for (int c = 0; c < 40 && n_acc < 6; c++) begin
            #1;
            if (req_ready != 0) begin
                chk($sformatf("rr_accept%0d", n_acc), req_ready, 4'(1 << exp_rr));
                exp_rr = (exp_rr + 1) % 3;
                n_acc++;
            end
            @(negedge clk);
        end
        chk("rr_accept_count", n_acc, 6);
        req_valid = '0;
        repeat (5) @(negedge clk);
        idle_inputs();

        // grant stall: request and payload held while gnt stays low, second requester waits
        @(negedge clk);
        req_valid = 4'b0001; req_addr[0] = 48'h7800_0040; req_we = 4'b0001; req_wdata[0] = 64'hDEAD;
        #1 chk("stall_accept", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0010; req_addr[1] = 48'h7800_0080; req_we = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall%0d_port_req", c), port_req, 2'b01);
            chk($sformatf("stall%0d_addr", c), port_addr[0], 17'h40);
            chk($sformatf("stall%0d_wdata", c), port_wdata[0], 64'hDEAD);
            chk($sformatf("stall%0d_we", c), port_we, 2'b01);
            chk($sformatf("stall%0d_ready", c), req_ready, 4'b0000);
            @(negedge clk);
        end
        port_gnt = 2'b01;
        #1 chk("stall_gnt_ready", req_ready, 4'b0000);
        @(negedge clk);
        port_gnt = 2'b00; port_rvalid = 2'b01; port_rdata[0] = 64'h0;
        #1 chk("stall_wait_ready", req_ready, 4'b0000);
        @(negedge clk);
        port_rvalid = 2'b00;
        #1;
        chk("stall_rsp", rsp_valid, 4'b0001);
        chk("stall_next_accept", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0; port_gnt = 2'b01; port_rvalid = 2'b01;
        repeat (4) @(negedge clk);
        idle_inputs();

        // reset while port 1 is in WAIT
        @(negedge clk);
        req_valid = 4'b0100; req_addr[2] = 48'h7802_0100;
        #1 chk("rst_accept", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0; port_gnt = 2'b10;
        @(negedge clk);
        port_gnt = 2'b00;
        rst_ni = 1'b0;
        #1;
        chk("rst_port_req", port_req, 0);
        chk("rst_port_addr", port_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ready", req_ready, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        port_rvalid = 2'b10; port_rdata[1] = 64'h99;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("rst_stale%0d_rsp", c), rsp_valid, 0);
            @(negedge clk);
            port_rvalid = 2'b00;
        end
        req_valid = 4'b0100; req_addr[2] = 48'h7802_0100;
        #1 chk("rst_new_accept", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0; port_gnt = 2'b10;
        #1 chk("rst_new_addr", port_addr[1], 17'h100);
        @(negedge clk);
        port_gnt = 2'b00; port_rvalid = 2'b10; port_rdata[1] = 64'h77;
        @(negedge clk);
        port_rvalid = 2'b00;
        #1;
        chk("rst_new_rsp", rsp_valid, 4'b0100);
        chk("rst_new_rdata", rsp_rdata, 64'h77);
        chk("rst_new_err", rsp_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
